// File: rtl/tcheck_mc_if.sv
// FIFO read-side bundle between a show-ahead packet FIFO (master) and tcheck_mc (slave).
interface tcheck_mc_if #(
  parameter int DATAWIDTH = 64
);
  logic [DATAWIDTH-1:0] packet_fifo_rd_data;
  logic                 packet_fifo_ne;
  logic                 packet_fifo_re;

  modport master (output packet_fifo_rd_data, output packet_fifo_ne, input packet_fifo_re);
  modport slave  (input packet_fifo_rd_data, input packet_fifo_ne, output packet_fifo_re);
endinterface

// File: rtl/tcheck_mc.sv
// Multi-channel packet checker: parses headers, checks per-channel sequence and payload content.
// Optional in-packet idle timeout is enabled by defining TCHECK_MC_TIMEOUT_EN.
module tcheck_mc #(
  parameter int DATAWIDTH = 64,
  parameter int NCHAN     = 4,
  parameter int CNTW      = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  tcheck_mc_if.slave      fifo,
  output logic [CNTW-1:0] packet_count,
  output logic [CNTW-1:0] error_count,
  output logic [CNTW-1:0] content_count,
  output logic [CNTW-1:0] short_count,
  output logic [CNTW-1:0] junk_count,
  output logic [CNTW-1:0] seq_count,
  output logic            busy
);

  typedef enum logic {HDR = 1'b0, PAY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            seq_q, seq_d;
  logic [15:0]            rem_q, rem_d;
  logic [15:0]            idx_q, idx_d;
  logic                   mm_q, mm_d;

  logic [DATAWIDTH-1:0]   word;
  logic                   take;
  logic                   marker;
  logic                   chan_ok;
  logic                   pay_mm;
  logic                   hdr_cycle;
  logic                   timeout_hit;
  logic [7:0]             w_chan;
  logic [15:0]            w_seq;
  logic [15:0]            w_len;
  logic [15:0]            exp_rd;
  logic [NCHAN*16-1:0]    exp_all;
  logic                   exp_we;
  logic                   ev_pkt, ev_content, ev_short, ev_junk, ev_seq;
  logic [5:0]             ev_vec;
  logic [6*CNTW-1:0]      cnt_all;

  // The checker never back-pressures: every available word is popped.
  assign word               = fifo.packet_fifo_rd_data;
  assign take               = fifo.packet_fifo_ne && !reset;
  assign fifo.packet_fifo_re = take;

  assign marker  = (word[DATAWIDTH-1 -: 8] == 8'hA5);
  assign w_chan  = word[39:32];
  assign w_seq   = word[31:16];
  assign w_len   = word[15:0];
  assign chan_ok = (32'(w_chan) < 32'(NCHAN));
  assign pay_mm  = (word != {(DATAWIDTH/32){seq_q, idx_q}});

  always_comb begin
    exp_rd = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (w_chan == 8'(c)) exp_rd = exp_all[c*16 +: 16];
    end
  end

`ifdef TCHECK_MC_TIMEOUT_EN
  localparam int IDW = $clog2(TIMEOUT + 1);
  logic [IDW-1:0] idle_q;

  assign timeout_hit = (state_q == PAY) && !fifo.packet_fifo_ne && (idle_q == IDW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || take || state_q != PAY) idle_q <= '0;
    else                                 idle_q <= idle_q + IDW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    mm_d       = mm_q;
    ev_pkt     = 1'b0;
    ev_content = 1'b0;
    ev_short   = 1'b0;
    ev_junk    = 1'b0;
    ev_seq     = 1'b0;
    exp_we     = 1'b0;
    hdr_cycle  = 1'b0;
    if (take) begin
      if (state_q == HDR) begin
        hdr_cycle = 1'b1;
      end else if (marker) begin
        // Premature header: drop the open packet and parse this word as a header.
        ev_short  = 1'b1;
        hdr_cycle = 1'b1;
        state_d   = HDR;
      end else if (rem_q == 16'd1) begin
        ev_pkt     = 1'b1;
        ev_content = mm_q | pay_mm;
        state_d    = HDR;
      end else begin
        rem_d = rem_q - 16'd1;
        idx_d = idx_q + 16'd1;
        mm_d  = mm_q | pay_mm;
      end
      if (hdr_cycle) begin
        if (!marker || !chan_ok) begin
          ev_junk = 1'b1;
        end else begin
          ev_seq = (w_seq != exp_rd);
          exp_we = 1'b1;
          if (w_len == 16'd0) begin
            ev_pkt = 1'b1;
          end else begin
            state_d = PAY;
            seq_d   = w_seq;
            rem_d   = w_len;
            idx_d   = 16'd0;
            mm_d    = 1'b0;
          end
        end
      end
    end else if (timeout_hit) begin
      ev_short = 1'b1;
      state_d  = HDR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HDR;
      seq_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
    end
  end

  assign busy = (state_q == PAY);

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    logic [15:0] exp_q;
    always_ff @(posedge clk) begin
      if (reset)                              exp_q <= '0;
      else if (exp_we && w_chan == 8'(gi))    exp_q <= w_seq + 16'd1;
    end
    assign exp_all[gi*16 +: 16] = exp_q;
  end

  // Counter order: packet, error, content, short, junk, seq.
  assign ev_vec = {ev_seq, ev_junk, ev_short, ev_content,
                   ev_content | ev_short | ev_junk | ev_seq, ev_pkt};

  for (genvar gi = 0; gi < 6; gi++) begin : g_cnt
    logic [CNTW-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset || clear)                 cnt_q <= '0;
      else if (ev_vec[gi] && cnt_q != '1) cnt_q <= cnt_q + CNTW'(1);
    end
    assign cnt_all[gi*CNTW +: CNTW] = cnt_q;
  end

  assign packet_count  = cnt_all[0*CNTW +: CNTW];
  assign error_count   = cnt_all[1*CNTW +: CNTW];
  assign content_count = cnt_all[2*CNTW +: CNTW];
  assign short_count   = cnt_all[3*CNTW +: CNTW];
  assign junk_count    = cnt_all[4*CNTW +: CNTW];
  assign seq_count     = cnt_all[5*CNTW +: CNTW];

endmodule

// File: tb/tb_tcheck_mc.sv
// Self-checking bench for tcheck_mc: packet-level reference model, directed cases and random traffic.
module tb_tcheck_mc;
  localparam int DW = 64;
  localparam int NC = 4;
  localparam int CW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset, clear;
  always #5 clk = ~clk;

  tcheck_mc_if #(.DATAWIDTH(DW)) fifo ();
  tcheck_mc_if #(.DATAWIDTH(DW)) fifo_s ();

  logic [CW-1:0] packet_count, error_count, content_count, short_count, junk_count, seq_count;
  logic          busy;
  logic [2:0]    s_pkt, s_err, s_content, s_short, s_junk, s_seq;
  logic          s_busy;

  tcheck_mc #(.DATAWIDTH(DW), .NCHAN(NC), .CNTW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .clear(clear), .fifo(fifo),
    .packet_count(packet_count), .error_count(error_count), .content_count(content_count),
    .short_count(short_count), .junk_count(junk_count), .seq_count(seq_count), .busy(busy)
  );

  // Narrow-counter instance used only to exercise saturation.
  tcheck_mc #(.DATAWIDTH(DW), .NCHAN(NC), .CNTW(3), .TIMEOUT(TO)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .fifo(fifo_s),
    .packet_count(s_pkt), .error_count(s_err), .content_count(s_content),
    .short_count(s_short), .junk_count(s_junk), .seq_count(s_seq), .busy(s_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_pkt, m_err, m_content, m_short, m_junk, m_seq;
  int m_exp[NC];
  bit m_open;
  bit gaps_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr_word(input int chan, input int seq, input int len);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1 -: 8] = 8'hA5;
    w[39:32]     = 8'(chan);
    w[31:16]     = 16'(seq);
    w[15:0]      = 16'(len);
    return w;
  endfunction

  function automatic logic [DW-1:0] pay_word(input int seq, input int k);
    logic [31:0] half;
    half = {16'(seq), 16'(k)};
    return {(DW/32){half}};
  endfunction

  function automatic logic [DW-1:0] junk_word();
    logic [DW-1:0] w;
    w = {$urandom, $urandom};
    if (w[DW-1 -: 8] == 8'hA5) w[DW-1 -: 8] = 8'h00;
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      fifo.packet_fifo_ne = 1'b0;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    if (gaps_en && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    @(negedge clk);
    fifo.packet_fifo_rd_data = w;
    fifo.packet_fifo_ne      = 1'b1;
  endtask

  task automatic model_zero();
    m_pkt = 0; m_err = 0; m_content = 0; m_short = 0; m_junk = 0; m_seq = 0;
  endtask

  task automatic check_all(input string tag);
    if (fifo.packet_fifo_ne) idle(1);
    check({tag, "/packet"},  64'(packet_count),  64'(m_pkt));
    check({tag, "/error"},   64'(error_count),   64'(m_err));
    check({tag, "/content"}, 64'(content_count), 64'(m_content));
    check({tag, "/short"},   64'(short_count),   64'(m_short));
    check({tag, "/junk"},    64'(junk_count),    64'(m_junk));
    check({tag, "/seq"},     64'(seq_count),     64'(m_seq));
    check({tag, "/busy"},    64'(busy),          64'(m_open));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    fifo.packet_fifo_ne = 1'b0;
    @(negedge clk);
    fifo.packet_fifo_rd_data = junk_word();
    fifo.packet_fifo_ne      = 1'b1;
    #1;
    check({tag, "/re_in_reset"}, 64'(fifo.packet_fifo_re), 64'd0);
    model_zero();
    m_open = 1'b0;
    foreach (m_exp[i]) m_exp[i] = 0;
    @(negedge clk);
    reset = 1'b0;
    fifo.packet_fifo_ne   = 1'b0;
    fifo_s.packet_fifo_ne = 1'b0;
    #1;
    check_all({tag, "/post_reset"});
  endtask

  // Packet-level reference: header word, then nsend of len payload words; bad_mask marks corrupted words.
  task automatic send_pkt(input int chan, input int seq, input int len, input int nsend, input int bad_mask);
    logic [DW-1:0] w;
    bit seq_bad;
    seq_bad = (seq != m_exp[chan]);
    if (m_open)  m_short++;
    if (seq_bad) m_seq++;
    if (m_open || seq_bad) m_err++;
    m_exp[chan] = (seq + 1) % 65536;
    m_open = 1'b0;
    $display("pkt ch=%0d seq=%0d len=%0d sent=%0d bad=%0h", chan, seq, len, nsend, bad_mask);
    push(hdr_word(chan, seq, len));
    for (int k = 0; k < nsend; k++) begin
      w = pay_word(seq, k);
      if (bad_mask[k]) w[0] = ~w[0];
      push(w);
    end
    if (nsend == len) begin
      m_pkt++;
      if (len > 0 && (bad_mask & ((1 << len) - 1)) != 0) begin
        m_content++;
        m_err++;
      end
    end else begin
      m_open = 1'b1;
    end
  endtask

  task automatic send_junk(input logic [DW-1:0] w);
    m_junk++;
    m_err++;
    $display("junk word=%016h", w);
    push(w);
  endtask

  initial begin
    int chan, seq, len, nsend, mask;
    reset = 1'b1;
    clear = 1'b0;
    fifo.packet_fifo_rd_data   = '0;
    fifo.packet_fifo_ne        = 1'b0;
    fifo_s.packet_fifo_rd_data = '0;
    fifo_s.packet_fifo_ne      = 1'b0;

    do_reset("init");
    send_junk(junk_word());
    #1;
    check("re_follows_ne", 64'(fifo.packet_fifo_re), 64'd1);
    check_all("first_junk");

    do_reset("rr");
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NC; c++) send_pkt(c, r, 5, 5, 0);
    check_all("round_robin");

    do_reset("seqgap");
    send_pkt(1, 0, 2, 2, 0);
    send_pkt(1, 2, 2, 2, 0);
    check_all("seq_gap");
    send_pkt(1, 3, 2, 2, 0);
    check_all("seq_resync");

    do_reset("content");
    send_pkt(0, 0, 6, 6, (1 << 2) | (1 << 4));
    check_all("content_twice");

    do_reset("short");
    send_pkt(2, 0, 8, 3, 0);
    check_all("short_open");
    send_pkt(2, 1, 4, 4, 0);
    check_all("short_then_ok");

    do_reset("junk");
    for (int i = 0; i < 3; i++) send_junk(junk_word());
    send_junk(hdr_word(7, 0, 3));
    check_all("junk_chan7");

    do_reset("wrap");
    send_pkt(3, 16'hFFFF, 0, 0, 0);
    send_pkt(3, 0, 1, 1, 0);
    check_all("l0_wrap");

    @(negedge clk);
    clear = 1'b1;
    fifo.packet_fifo_rd_data = junk_word();
    fifo.packet_fifo_ne      = 1'b1;
    fifo_s.packet_fifo_ne    = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    fifo.packet_fifo_ne = 1'b0;
    model_zero();
    check_all("clear_wins");
    send_pkt(3, 1, 2, 2, 0);
    check_all("after_clear");

    do_reset("midrst");
    send_pkt(1, 0, 5, 2, 0);
    check_all("open_before_reset");
    do_reset("midrst2");
    send_pkt(1, 0, 1, 1, 0);
    check_all("after_mid_reset");

    do_reset("idle");
    send_pkt(0, 0, 4, 1, 0);
    idle(16);
    check_all("idle_15");
    idle(1);
`ifdef TCHECK_MC_TIMEOUT_EN
    m_short++;
    m_err++;
    m_open = 1'b0;
`endif
    check_all("idle_16");
    send_pkt(0, 1, 1, 1, 0);
    check_all("after_idle");

    do_reset("random");
    gaps_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!m_open && $urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) send_junk(junk_word());
        else send_junk(hdr_word($urandom_range(NC, 255), $urandom_range(0, 100), 2));
      end
      chan  = $urandom_range(0, NC - 1);
      seq   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 16'h9FFF) : m_exp[chan];
      len   = $urandom_range(0, 6);
      nsend = len;
      mask  = 0;
      if (len > 0 && $urandom_range(0, 6) == 0) nsend = $urandom_range(0, len - 1);
      if (len > 0 && $urandom_range(0, 4) == 0) mask = 1 << $urandom_range(0, len - 1);
      send_pkt(chan, seq, len, nsend, mask);
      if (i % 25 == 24) check_all($sformatf("random_%0d", i));
    end
    gaps_en = 1'b0;

    do_reset("sat");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fifo_s.packet_fifo_rd_data = junk_word();
      fifo_s.packet_fifo_ne      = 1'b1;
    end
    @(negedge clk);
    fifo_s.packet_fifo_ne = 1'b0;
    check("sat_junk",  64'(s_junk), 64'd7);
    check("sat_error", 64'(s_err),  64'd7);
    check("sat_packet", 64'(s_pkt), 64'd0);
    @(negedge clk);
    clear = 1'b1;
    fifo_s.packet_fifo_rd_data = junk_word();
    fifo_s.packet_fifo_ne      = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    fifo_s.packet_fifo_ne = 1'b0;
    check("sat_clear_junk", 64'(s_junk), 64'd0);
    check("sat_clear_error", 64'(s_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
